// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-flush / memory-freeze sequencing for the 5-stage pipeline
// Optional perf counters built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_ID_EX,
  input  logic [4:0]  rd_ID_EX,
  input  logic [4:0]  rs1_IF_ID,
  input  logic [4:0]  rs2_IF_ID,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        branch_taken_EX,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        pc_sel_branch,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        ex_mem_write,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] freeze_cycles
);

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu_hit;

  assign lu_hit = memread_ID_EX && (rd_ID_EX != 5'd0) &&
                  ((use_rs1 && (rd_ID_EX == rs1_IF_ID)) ||
                   (use_rs2 && (rd_ID_EX == rs2_IF_ID)));

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b0;
    if (reset) begin
      state_d     = RUN;
      stall_cnt_d = '0;
    end else if (mem_busy) begin
      // Freeze: everything holds, including a taken branch still sitting in EX.
    end else if (branch_taken_EX) begin
      pc_sel_branch = 1'b1;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_write  = 1'b1;
      state_d       = RUN;
      stall_cnt_d   = '0;
    end else if ((state_q == LU_STALL) || lu_hit) begin
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_write = 1'b1;
      if (state_q == LU_STALL) begin
        stall_cnt_d = stall_cnt_q - CNT_W'(1);
        if (stall_cnt_q == CNT_W'(1)) state_d = RUN;
      end else if (LOAD_LAT > 1) begin
        state_d     = LU_STALL;
        stall_cnt_d = RELOAD;
      end
    end else begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q, freeze_cycles_q;

  // Load-use bubble cycles are exactly those with a bubble but no branch redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q  <= '0;
      flush_count_q   <= '0;
      freeze_cycles_q <= '0;
    end else begin
      if (id_ex_bubble && !pc_sel_branch) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (pc_sel_branch) flush_count_q <= flush_count_q + 32'd1;
      if (mem_busy) freeze_cycles_q <= freeze_cycles_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign flush_count   = flush_count_q;
  assign freeze_cycles = freeze_cycles_q;
`else
  assign stall_cycles  = 32'd0;
  assign flush_count   = 32'd0;
  assign freeze_cycles = 32'd0;
`endif

endmodule
